// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable framing.
// Majority-voted bits, break handling and a one-word holding register.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic                 perr,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_VOTE = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    logic                 s1, s2, s3;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        nxt_cnt;
    logic [3:0]           idx;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, pflag, fflag, zero, good;
    logic                 vote, at_vote, at_last, fe, brk;

    // samp holds the two previous line samples, so at C_VOTE the
    // window covers counts OVERSAMPLE/2-1 .. OVERSAMPLE/2+1
    assign vote    = (samp[1] & samp[0]) | (samp[1] & s2) | (samp[0] & s2);
    assign at_vote = (cnt == C_VOTE);
    assign at_last = (cnt == C_LAST);
    assign nxt_cnt = at_last ? '0 : cnt + 1'b1;
    assign fe      = fflag | ~vote;
    assign brk     = fe & zero & ~vote;
    assign overrun = done & good & valid & ~ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            samp    <= 2'b11;
            shreg   <= '0;
            par_acc <= 1'b0;
            pflag   <= 1'b0;
            fflag   <= 1'b0;
            zero    <= 1'b0;
            good    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            perr    <= 1'b0;
        end else begin
            samp <= {samp[0], s2};
            done <= 1'b0;
            err  <= 1'b0;
            perr <= 1'b0;
            if (!en) begin
                state <= S_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (s3 && !s2) begin
                            state   <= S_START;
                            cnt     <= '0;
                            idx     <= '0;
                            par_acc <= 1'b0;
                            pflag   <= 1'b0;
                            fflag   <= 1'b0;
                            zero    <= 1'b1;
                        end
                    end
                    S_START: begin
                        cnt <= nxt_cnt;
                        if (at_vote) begin
                            if (vote) begin
                                state <= S_IDLE;
                                cnt   <= '0;
                            end else begin
                                busy <= 1'b1;
                            end
                        end else if (at_last) begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        cnt <= nxt_cnt;
                        if (at_vote) begin
                            shreg   <= {vote, shreg[DATA_BITS-1:1]};
                            par_acc <= par_acc ^ vote;
                            if (vote) zero <= 1'b0;
                        end
                        if (at_last) begin
                            if (idx == LAST_D) begin
                                idx   <= '0;
                                state <= (PARITY != 0) ? S_PAR : S_STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    S_PAR: begin
                        cnt <= nxt_cnt;
                        if (at_vote) begin
                            pflag <= (PARITY == 1) ? (par_acc ^ vote)
                                                   : ~(par_acc ^ vote);
                            if (vote) zero <= 1'b0;
                        end
                        if (at_last) state <= S_STOP;
                    end
                    S_STOP: begin
                        cnt <= nxt_cnt;
                        if (at_vote) begin
                            if (!vote) fflag <= 1'b1;
                            else zero <= 1'b0;
                            if (idx == LAST_S) begin
                                done  <= 1'b1;
                                err   <= fe;
                                perr  <= pflag;
                                good  <= ~fe & ~pflag;
                                busy  <= 1'b0;
                                cnt   <= '0;
                                state <= brk ? S_WAIT : S_IDLE;
                            end
                        end else if (at_last) begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        // re-arm only after a full bit time of idle line
                        cnt <= s2 ? nxt_cnt : '0;
                        if (s2 && at_last) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else if (done && good) begin
            if (!valid || ready) begin
                out   <= shreg;
                valid <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: vector table plus hand-written corner sequences.
// Per-instance scoreboards are checked on every done pulse.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] rx, rdy;
    logic [7:0] out_w [2];
    logic [1:0] valid_w, done_w, busy_w, err_w, perr_w, ovr_w;
    int         nvec = 0;
    int         nmis = 0;

    always #5 clk = ~clk;

    uart_rx_param dut (
        .clk(clk), .rst(rst), .en(en), .in(rx[0]),
        .out(out_w[0]), .valid(valid_w[0]), .ready(rdy[0]),
        .done(done_w[0]), .busy(busy_w[0]), .err(err_w[0]),
        .perr(perr_w[0]), .overrun(ovr_w[0])
    );

    uart_rx_param #(.PARITY(1)) dutp (
        .clk(clk), .rst(rst), .en(en), .in(rx[1]),
        .out(out_w[1]), .valid(valid_w[1]), .ready(rdy[1]),
        .done(done_w[1]), .busy(busy_w[1]), .err(err_w[1]),
        .perr(perr_w[1]), .overrun(ovr_w[1])
    );

    typedef struct {
        logic       err, perr, ovr, vld;
        logic [7:0] dat;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        bit         sb, rd, e, ov, v;
        logic [7:0] o;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : m
        exp_t q[$];
        initial begin
            exp_t cur;
            bit   pend;
            pend = 0;
            forever begin
                @(negedge clk);
                #2;
                if (pend) begin
                    pend = 0;
                    chk($sformatf("out%0d", g), 32'(out_w[g]), 32'(cur.dat));
                    chk($sformatf("valid%0d", g), 32'(valid_w[g]), 32'(cur.vld));
                end
                if (done_w[g]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("stray_done%0d", g), 32'(1), 32'(0));
                    end else begin
                        cur = q.pop_front();
                        chk($sformatf("err%0d", g), 32'(err_w[g]), 32'(cur.err));
                        chk($sformatf("perr%0d", g), 32'(perr_w[g]), 32'(cur.perr));
                        chk($sformatf("ovr%0d", g), 32'(ovr_w[g]), 32'(cur.ovr));
                        pend = 1;
                    end
                end else if (err_w[g] || perr_w[g] || ovr_w[g]) begin
                    chk($sformatf("stray_pulse%0d", g), 32'(1), 32'(0));
                end
            end
        end
    end

    task automatic push(input int g, input exp_t e);
        if (g == 0) m[0].q.push_back(e);
        else m[1].q.push_back(e);
    endtask

    // one bit time; optionally raise ready exactly in the done cycle
    task automatic bitx(input int g, input logic b, input bit rod);
        rx[g] = b;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rod) begin
                if (done_w[g]) begin
                    #1;
                    rdy[g] = 1'b1;
                end else begin
                    rdy[g] = 1'b0;
                end
            end
        end
    endtask

    task automatic send(input int g, input logic [7:0] d, input bit up,
                        input bit pb, input bit sb, input bit rod);
        bitx(g, 1'b0, rod);
        for (int i = 0; i < 8; i++) bitx(g, d[i], rod);
        if (up) bitx(g, pb, rod);
        bitx(g, sb, rod);
    endtask

    task automatic idle(input int g, input int nb);
        rx[g] = 1'b1;
        repeat (nb * 16) @(negedge clk);
    endtask

    task automatic pulse_rdy(input int g);
        rdy[g] = 1'b1;
        @(negedge clk);
        rdy[g] = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_out"}, 32'(out_w[0]), 32'(0));
        chk({nm, "_valid"}, 32'(valid_w[0]), 32'(0));
        chk({nm, "_busy"}, 32'(busy_w[0]), 32'(0));
        chk({nm, "_done"}, 32'(done_w[0]), 32'(0));
        chk({nm, "_err"}, 32'(err_w[0]), 32'(0));
        chk({nm, "_ovr"}, 32'(ovr_w[0]), 32'(0));
    endtask

    task automatic partial(input int g);
        bitx(g, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bitx(g, 1'b1, 1'b0);
    endtask

    initial begin
        vec_t tbl[8];
        bit   seen;
        tbl[0] = '{d:8'h55, sb:1, rd:0, e:0, ov:0, v:1, o:8'h55};
        tbl[1] = '{d:8'hFF, sb:0, rd:0, e:1, ov:0, v:1, o:8'h55};
        tbl[2] = '{d:8'h3C, sb:1, rd:0, e:0, ov:1, v:1, o:8'h55};
        tbl[3] = '{d:8'h3C, sb:1, rd:1, e:0, ov:0, v:1, o:8'h3C};
        tbl[4] = '{d:8'h00, sb:1, rd:0, e:0, ov:0, v:1, o:8'h00};
        tbl[5] = '{d:8'h80, sb:1, rd:1, e:0, ov:0, v:1, o:8'h80};
        tbl[6] = '{d:8'hA5, sb:0, rd:1, e:1, ov:0, v:0, o:8'h80};
        tbl[7] = '{d:8'h01, sb:1, rd:0, e:0, ov:0, v:1, o:8'h01};

        rst = 1'b1;
        en  = 1'b1;
        rx  = 2'b11;
        rdy = 2'b00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_valid1", 32'(valid_w[1]), 32'(0));
        chk("reset_busy1", 32'(busy_w[1]), 32'(0));
        rst = 1'b0;
        idle(0, 1);

        for (int i = 0; i < 8; i++) begin
            rdy[0] = tbl[i].rd;
            idle(0, 2);
            push(0, '{err:tbl[i].e, perr:1'b0, ovr:tbl[i].ov,
                      vld:tbl[i].v, dat:tbl[i].o});
            send(0, tbl[i].d, 1'b0, 1'b0, tbl[i].sb, 1'b0);
        end
        rdy[0] = 1'b0;
        idle(0, 2);

        // handshake clears valid one cycle later, word stays
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        chk("hs_valid", 32'(valid_w[0]), 32'(0));
        chk("hs_out", 32'(out_w[0]), 32'(8'h01));

        // 30 ns glitch is a false start
        rx[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx[0] = 1'b1;
        seen = 0;
        repeat (32) begin
            @(negedge clk);
            seen |= busy_w[0];
        end
        chk("glitch_busy", 32'(seen), 32'(0));
        push(0, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'h3C});
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(0, 2);

        // break: all-zero frame, then start edges ignored until re-arm
        push(0, '{err:1'b1, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'h3C});
        send(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        seen = 0;
        rx[0] = 1'b0;
        repeat (48) begin
            @(negedge clk);
            seen |= busy_w[0];
        end
        rx[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            seen |= busy_w[0];
        end
        rx[0] = 1'b0;
        repeat (32) begin
            @(negedge clk);
            seen |= busy_w[0];
        end
        chk("break_busy", 32'(seen), 32'(0));
        rx[0] = 1'b1;
        pulse_rdy(0);
        idle(0, 2);
        push(0, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'h96});
        send(0, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(0, 2);

        // overrun, then ready exactly in the done cycle
        pulse_rdy(0);
        push(0, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'h11});
        send(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(0, 1);
        push(0, '{err:1'b0, perr:1'b0, ovr:1'b1, vld:1'b1, dat:8'h11});
        send(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(0, 1);
        push(0, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'h22});
        send(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        rdy[0] = 1'b0;
        idle(0, 2);

        // reset mid-data
        partial(0);
        chk("rst_pre_busy", 32'(busy_w[0]), 32'(1));
        rx[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midrst");
        idle(0, 2);
        push(0, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'h5A});
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(0, 2);

        // enable drop mid-data
        partial(0);
        chk("en_pre_busy", 32'(busy_w[0]), 32'(1));
        rx[0] = 1'b1;
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk("en_busy", 32'(busy_w[0]), 32'(0));
        chk("en_out", 32'(out_w[0]), 32'(8'h5A));
        chk("en_valid", 32'(valid_w[0]), 32'(1));
        idle(0, 2);
        pulse_rdy(0);
        push(0, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'hC3});
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(0, 2);

        // even parity instance
        push(1, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'hA3});
        send(1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1, 2);
        push(1, '{err:1'b0, perr:1'b1, ovr:1'b0, vld:1'b1, dat:8'hA3});
        send(1, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b0);
        rdy[1] = 1'b1;
        idle(1, 2);
        push(1, '{err:1'b0, perr:1'b0, ovr:1'b0, vld:1'b1, dat:8'h07});
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        rdy[1] = 1'b0;
        idle(1, 2);

        chk("q0_left", 32'(m[0].q.size()), 32'(0));
        chk("q1_left", 32'(m[1].q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: clk cycles per bit, legal even 8..64.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked, legal 1 or 2.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port en, input, 1: receiver enable; low aborts any frame and holds idle.
REQ-008 SHALL have port in, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port out, output, DATA_BITS: received word holding register, LSB is first bit received.
REQ-010 SHALL have port valid, output, 1: out holds an unconsumed good word.
REQ-011 SHALL have port ready, input, 1: consumer accepts out when valid and ready are both high.
REQ-012 SHALL have port done, output, 1: one-cycle pulse per completed frame.
REQ-013 SHALL have port busy, output, 1: high from the validated start bit to frame end.
REQ-014 SHALL have port err, output, 1: framing-error pulse, coincident with done.
REQ-015 SHALL have port perr, output, 1: parity-error pulse, coincident with done.
REQ-016 SHALL have port overrun, output, 1: one-cycle pulse when a good frame is lost.

Function
REQ-017 SHALL pass in through a 2-flop synchroniser; all decoding uses the synchronised line.
REQ-018 SHALL run FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE: on a high-to-low edge of the synchronised line with en=1 -> START; sample counter cleared.
REQ-020 SHALL take each bit by majority vote of the 3 samples at counter values OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-021 START: voted 1 -> false start, back to IDLE, no done, busy never set; voted 0 -> busy=1, DATA.
REQ-022 DATA: DATA_BITS bits taken OVERSAMPLE cycles apart, LSB first; then PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: perr flag = (XOR of data bits XOR parity bit) != 0 for even; == 0 for odd.
REQ-024 STOP: STOP_BITS bits checked; any voted 0 sets the framing flag.
REQ-025 Frame end is the vote of the last stop bit; done, err, perr assert on the next cycle for exactly 1 cycle, and busy drops in that same cycle.
REQ-026 Framing error with all data, parity and stop bits voted 0 (break) -> WAIT_HIGH; re-arm to IDLE only after the synchronised line has been 1 for one full bit time; otherwise frame end -> IDLE.
REQ-027 Frame with err=0 and perr=0 is good; a frame with err=1 or perr=1 SHALL NOT change out or valid.
REQ-028 Good frame with valid=0, or with valid=1 and ready=1 in the done cycle: out loaded, valid=1.
REQ-029 Good frame with valid=1 and ready=0 in the done cycle: new word discarded, out unchanged, overrun pulses with done.
REQ-030 Handshake: valid=1 and ready=1 with no good frame completing clears valid the next cycle; out holds its last value.
REQ-031 en=0: FSM -> IDLE next cycle, busy=0, no done/err/perr; out and valid unaffected.
REQ-032 SHALL accept a new start edge in IDLE the cycle after frame end (back-to-back frames).

Reset
REQ-033 rst=1 at a clock edge: FSM IDLE, counters 0, synchroniser flops 1, out=0, valid=0, done=busy=err=perr=overrun=0.
REQ-034 rst SHALL override en and any frame in progress; the partial frame is discarded with no pulses.

Verification (defaults unless stated; clk period 10 ns, bit time 160 ns)
REQ-035 Send 0x55, 1 stop -> one done pulse, out=0x55, valid=1, err=perr=0; assert ready -> valid=0 next cycle.
REQ-036 PARITY=1: send 0xA3 with parity bit 0 -> good frame, out=0xA3; resend with parity bit 1 -> perr=1, out still 0xA3.
REQ-037 Send 0xFF with stop bit 0 -> err=1, valid unchanged; hold line low 3 bit times (break) -> start edges ignored until line high 160 ns.
REQ-038 Line low for 30 ns glitch -> no busy, no done; then 0x3C -> out=0x3C.
REQ-039 Two good frames 0x11 then 0x22 with ready=0 -> second done has overrun=1, out=0x11; repeat with ready=1 in second done cycle -> out=0x22, no overrun.
REQ-040 rst=1 for 1 cycle mid-data of frame 0x77 -> all outputs 0 next cycle, no done; next frame 0x5A received correctly; same with en=0 mid-frame.
